// File: rtl/trace_ring_logger_pkg.sv
// Shared types for the trace ring logger: trigger FSM states and buffer mode encoding.
package DTB_PKG;

  typedef enum logic [1:0] {
    TRG_ARMED  = 2'd0,
    TRG_DELAY  = 2'd1,
    TRG_FROZEN = 2'd2
  } trg_state_e;

  typedef enum logic {
    MODE_TRACE  = 1'b0,
    MODE_STREAM = 1'b1
  } mode_e;

endpackage

// File: rtl/trace_ring_logger_if.sv
// Bus bundle between the tracer/host/memory side (master) and the ring logger (slave).
// Drop-statistics signals exist only when TRACE_RING_DROP_STATS_EN is defined.
interface trace_ring_if #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 64,
  parameter int DELAY_BITS = 3
);
  localparam int AW = $clog2(DEPTH);

  logic                  FLUSH_I;
  logic                  MODE_I;
  logic [DELAY_BITS-1:0] DELAY_I;
  logic                  TRG_EVENT_I;
  logic                  STORE_I;
  logic [WIDTH-1:0]      DATA_I;
  logic                  RW_TURN_I;
  logic                  WRITE_O;
  logic [AW-1:0]         WRITE_PTR_O;
  logic [WIDTH-1:0]      DMEM_O;
  logic [AW-1:0]         READ_PTR_O;
  logic [WIDTH-1:0]      DMEM_I;
  logic                  REQ_I;
  logic                  LOAD_O;
  logic [WIDTH-1:0]      DATA_O;
  logic                  TRG_DELAYED_O;
  logic [AW-1:0]         EVENT_ADDR_O;
  logic [AW:0]           COUNT_O;
`ifdef TRACE_RING_DROP_STATS_EN
  logic                  OVERFLOW_O;
  logic [15:0]           DROP_CNT_O;
`endif

  modport master (
    output FLUSH_I, MODE_I, DELAY_I, TRG_EVENT_I, STORE_I, DATA_I, RW_TURN_I, DMEM_I, REQ_I,
    input  WRITE_O, WRITE_PTR_O, DMEM_O, READ_PTR_O, LOAD_O, DATA_O,
           TRG_DELAYED_O, EVENT_ADDR_O, COUNT_O
`ifdef TRACE_RING_DROP_STATS_EN
    , input OVERFLOW_O, DROP_CNT_O
`endif
  );

  modport slave (
    input  FLUSH_I, MODE_I, DELAY_I, TRG_EVENT_I, STORE_I, DATA_I, RW_TURN_I, DMEM_I, REQ_I,
    output WRITE_O, WRITE_PTR_O, DMEM_O, READ_PTR_O, LOAD_O, DATA_O,
           TRG_DELAYED_O, EVENT_ADDR_O, COUNT_O
`ifdef TRACE_RING_DROP_STATS_EN
    , output OVERFLOW_O, DROP_CNT_O
`endif
  );

endinterface

// File: rtl/trace_ring_logger_trigger.sv
// Trigger FSM for the ring logger: records the write address at the trigger, then counts
// a post-trigger window of committed writes before freezing.
module trace_trigger_fsm
  import DTB_PKG::*;
#(
  parameter int DEPTH      = 64,
  parameter int DELAY_BITS = 3
) (
  input  logic                     CLK_I,
  input  logic                     RST_NI,
  input  logic                     FLUSH_I,
  input  logic                     TRG_EVENT_I,
  input  logic [DELAY_BITS-1:0]    DELAY_I,
  input  logic                     COMMIT_I,
  input  logic [$clog2(DEPTH)-1:0] WRITE_PTR_I,
  output logic                     FROZEN_O,
  output logic [$clog2(DEPTH)-1:0] EVENT_ADDR_O
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = DELAY_BITS + AW;

  trg_state_e    r_state;
  trg_state_e    w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [AW-1:0] r_addr;
  logic [AW-1:0] w_addr_nxt;
  logic [PW-1:0] w_scaled;
  logic [CW-1:0] w_load;

  // DELAY_I is a fraction of DEPTH in 1/2^DELAY_BITS steps; DEPTH is a power of two so a shift scales it.
  assign w_scaled = {{AW{1'b0}}, DELAY_I} << AW;
  assign w_load   = CW'(w_scaled >> DELAY_BITS);

  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      r_state <= TRG_ARMED;
      r_cnt   <= '0;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_addr  <= w_addr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_addr_nxt  = r_addr;
    unique case (r_state)
      TRG_ARMED: begin
        if (TRG_EVENT_I) begin
          w_addr_nxt = WRITE_PTR_I;
          // A window that scales to zero words freezes immediately.
          if (w_load == '0) begin
            w_state_nxt = TRG_FROZEN;
          end else begin
            w_state_nxt = TRG_DELAY;
            w_cnt_nxt   = w_load;
          end
        end
      end
      TRG_DELAY: begin
        if (COMMIT_I) begin
          w_cnt_nxt = r_cnt - CW'(1);
          if (r_cnt == CW'(1)) w_state_nxt = TRG_FROZEN;
        end
      end
      TRG_FROZEN: begin
        w_state_nxt = TRG_FROZEN;
      end
      default: begin
        w_state_nxt = TRG_ARMED;
      end
    endcase
    if (FLUSH_I) begin
      w_state_nxt = TRG_ARMED;
      w_cnt_nxt   = '0;
      w_addr_nxt  = '0;
    end
  end

  assign FROZEN_O     = (r_state == TRG_FROZEN);
  assign EVENT_ADDR_O = r_addr;

endmodule

// File: rtl/trace_ring_logger.sv
// Trace ring logger top: ring-overwrite trace buffer or lossless streaming FIFO over an
// external slotted memory. Optional drop statistics: define TRACE_RING_DROP_STATS_EN.
module trace_ring_logger
  import DTB_PKG::*;
#(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 64,
  parameter int DELAY_BITS = 3
) (
  input logic         CLK_I,
  input logic         RST_NI,
  trace_ring_if.slave bus
);
  localparam int            AW   = $clog2(DEPTH);
  localparam int            CW   = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             r_wpend;
  logic             r_rpend;
  logic             r_load;
  logic [WIDTH-1:0] r_dmem;
  logic [WIDTH-1:0] r_data;
  logic             w_stream;
  logic             w_full;
  logic             w_frozen;
  logic             w_commit;
  logic             w_read;
  logic [AW-1:0]    w_event_addr;

  assign w_stream = (mode_e'(bus.MODE_I) == MODE_STREAM);
  assign w_full   = (r_count == FULL);
  // Streaming never loses data (full holds the write); trace mode stops only once frozen.
  assign w_commit = r_wpend && bus.RW_TURN_I && !(w_stream && w_full) && !(!w_stream && w_frozen);
  assign w_read   = r_rpend && !bus.RW_TURN_I && (r_count != '0);

  trace_trigger_fsm #(
    .DEPTH      (DEPTH),
    .DELAY_BITS (DELAY_BITS)
  ) u_trigger (
    .CLK_I        (CLK_I),
    .RST_NI       (RST_NI),
    .FLUSH_I      (bus.FLUSH_I),
    .TRG_EVENT_I  (bus.TRG_EVENT_I),
    .DELAY_I      (bus.DELAY_I),
    .COMMIT_I     (w_commit),
    .WRITE_PTR_I  (r_wptr),
    .FROZEN_O     (w_frozen),
    .EVENT_ADDR_O (w_event_addr)
  );

  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_wpend <= 1'b0;
      r_rpend <= 1'b0;
      r_load  <= 1'b0;
      r_dmem  <= '0;
      r_data  <= '0;
    end else if (bus.FLUSH_I) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_wpend <= 1'b0;
      r_rpend <= 1'b0;
      r_load  <= 1'b0;
    end else begin
      r_load  <= w_read;
      r_rpend <= bus.REQ_I | (r_rpend & ~w_read);
      if (bus.STORE_I) begin
        r_dmem  <= bus.DATA_I;
        r_wpend <= 1'b1;
      end else if (w_commit) begin
        r_wpend <= 1'b0;
      end
      // A full commit can only happen in trace mode; it pushes the oldest word out.
      if (w_commit) begin
        r_wptr <= r_wptr + AW'(1);
        if (w_full) r_rptr  <= r_rptr + AW'(1);
        else        r_count <= r_count + CW'(1);
      end else if (w_read) begin
        r_data  <= bus.DMEM_I;
        r_rptr  <= r_rptr + AW'(1);
        r_count <= r_count - CW'(1);
      end
    end
  end

`ifdef TRACE_RING_DROP_STATS_EN
  logic        w_drop;
  logic        r_overflow;
  logic [15:0] r_drop_cnt;

  assign w_drop = bus.STORE_I && r_wpend && !w_commit;

  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (bus.FLUSH_I) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign bus.OVERFLOW_O = r_overflow;
  assign bus.DROP_CNT_O = r_drop_cnt;
`else
  // Without statistics an overwritten pending word is simply lost.
`endif

  assign bus.WRITE_O       = r_wpend;
  assign bus.WRITE_PTR_O   = r_wptr;
  assign bus.DMEM_O        = r_dmem;
  assign bus.READ_PTR_O    = r_rptr;
  assign bus.LOAD_O        = r_load;
  assign bus.DATA_O        = r_data;
  assign bus.TRG_DELAYED_O = w_frozen;
  assign bus.EVENT_ADDR_O  = w_event_addr;
  assign bus.COUNT_O       = r_count;

endmodule

// File: tb/tb_trace_ring_logger.sv
// Directed bench for trace_ring_logger (DEPTH=8, WIDTH=16, DELAY_BITS=3) with a slotted memory model.
module tb_trace_ring_logger;

  logic clock;
  logic resetN;
  int   nCompared;
  int   nFailed;

  trace_ring_if #(.WIDTH(16), .DEPTH(8), .DELAY_BITS(3)) bus ();

  trace_ring_logger #(.WIDTH(16), .DEPTH(8), .DELAY_BITS(3)) dut (
    .CLK_I  (clock),
    .RST_NI (resetN),
    .bus    (bus)
  );

  // Memory writes on a write slot whenever a word is offered; reads are combinational.
  logic [15:0] mem [8];
  always @(posedge clock) if (bus.WRITE_O && bus.RW_TURN_I) mem[bus.WRITE_PTR_O] <= bus.DMEM_O;
  assign bus.DMEM_I = mem[bus.READ_PTR_O];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nCompared++;
    assert (observed === expected) else begin
      nFailed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic store, input logic [15:0] data, input logic turn, input logic req);
    bus.STORE_I   = store;
    bus.DATA_I    = data;
    bus.RW_TURN_I = turn;
    bus.REQ_I     = req;
    step();
    bus.STORE_I = 1'b0;
    bus.REQ_I   = 1'b0;
  endtask

  task automatic writeWord(input logic [15:0] data);
    applyStimulus(1'b1, data, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
  endtask

  task automatic flush();
    bus.FLUSH_I = 1'b1;
    step();
    bus.FLUSH_I = 1'b0;
  endtask

  initial begin
    nCompared       = 0;
    nFailed         = 0;
    resetN          = 1'b1;
    bus.FLUSH_I     = 1'b0;
    bus.MODE_I      = 1'b0;
    bus.DELAY_I     = 3'd0;
    bus.TRG_EVENT_I = 1'b0;
    bus.STORE_I     = 1'b0;
    bus.DATA_I      = 16'h0;
    bus.RW_TURN_I   = 1'b0;
    bus.REQ_I       = 1'b0;
    #1 resetN = 1'b0;
    #2;
    checkOutput("rst_wptr", 32'(bus.WRITE_PTR_O), 32'd0);
    checkOutput("rst_count", 32'(bus.COUNT_O), 32'd0);
    checkOutput("rst_write", 32'(bus.WRITE_O), 32'd0);
    checkOutput("rst_load", 32'(bus.LOAD_O), 32'd0);
    checkOutput("rst_trg", 32'(bus.TRG_DELAYED_O), 32'd0);
    #10 resetN = 1'b1;
    step();

    $display("[TB] trace mode wrap: 10 stores into 8 slots");
    for (int i = 1; i <= 10; i++) begin
      writeWord(16'hA000 + 16'(i));
      if (i == 1) begin
        checkOutput("wrap_first_wptr", 32'(bus.WRITE_PTR_O), 32'd1);
        checkOutput("wrap_first_count", 32'(bus.COUNT_O), 32'd1);
      end
    end
    checkOutput("wrap_wptr", 32'(bus.WRITE_PTR_O), 32'd2);
    checkOutput("wrap_rptr", 32'(bus.READ_PTR_O), 32'd2);
    checkOutput("wrap_count", 32'(bus.COUNT_O), 32'd8);
    checkOutput("wrap_write", 32'(bus.WRITE_O), 32'd0);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
    checkOutput("wrap_load", 32'(bus.LOAD_O), 32'd1);
    checkOutput("wrap_oldest", 32'(bus.DATA_O), 32'hA003);
    checkOutput("wrap_rd_rptr", 32'(bus.READ_PTR_O), 32'd3);
    checkOutput("wrap_rd_count", 32'(bus.COUNT_O), 32'd7);
    step();
    checkOutput("wrap_load_pulse", 32'(bus.LOAD_O), 32'd0);
    flush();
    checkOutput("flush_wptr", 32'(bus.WRITE_PTR_O), 32'd0);
    checkOutput("flush_count", 32'(bus.COUNT_O), 32'd0);

    $display("[TB] trace mode trigger with half-ring delay");
    bus.DELAY_I = 3'd4;
    for (int i = 0; i < 3; i++) writeWord(16'hB000 + 16'(i));
    bus.TRG_EVENT_I = 1'b1;
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
    bus.TRG_EVENT_I = 1'b0;
    checkOutput("trg_event_addr", 32'(bus.EVENT_ADDR_O), 32'd3);
    checkOutput("trg_not_yet", 32'(bus.TRG_DELAYED_O), 32'd0);
    for (int i = 3; i < 7; i++) begin
      writeWord(16'hB000 + 16'(i));
      if (i == 5) checkOutput("trg_after3", 32'(bus.TRG_DELAYED_O), 32'd0);
    end
    checkOutput("trg_frozen", 32'(bus.TRG_DELAYED_O), 32'd1);
    checkOutput("trg_wptr", 32'(bus.WRITE_PTR_O), 32'd7);
    writeWord(16'hB007);
    checkOutput("frozen_wptr", 32'(bus.WRITE_PTR_O), 32'd7);
    checkOutput("frozen_count", 32'(bus.COUNT_O), 32'd7);
    checkOutput("frozen_write", 32'(bus.WRITE_O), 32'd1);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
    checkOutput("frozen_load", 32'(bus.LOAD_O), 32'd1);
    checkOutput("frozen_data", 32'(bus.DATA_O), 32'hB000);
    checkOutput("frozen_rd_count", 32'(bus.COUNT_O), 32'd6);
    flush();
    checkOutput("flush2_trg", 32'(bus.TRG_DELAYED_O), 32'd0);
    checkOutput("flush2_write", 32'(bus.WRITE_O), 32'd0);
    checkOutput("flush2_event", 32'(bus.EVENT_ADDR_O), 32'd0);

    $display("[TB] streaming: zero delay trigger and flush against commit");
    bus.MODE_I      = 1'b1;
    bus.DELAY_I     = 3'd0;
    bus.TRG_EVENT_I = 1'b1;
    applyStimulus(1'b1, 16'hC001, 1'b0, 1'b0);
    bus.TRG_EVENT_I = 1'b0;
    checkOutput("zero_delay_frozen", 32'(bus.TRG_DELAYED_O), 32'd1);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    checkOutput("stream_frozen_wptr", 32'(bus.WRITE_PTR_O), 32'd1);
    checkOutput("stream_frozen_count", 32'(bus.COUNT_O), 32'd1);
    applyStimulus(1'b1, 16'hC002, 1'b0, 1'b0);
    bus.FLUSH_I = 1'b1;
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    bus.FLUSH_I = 1'b0;
    checkOutput("flush_commit_wptr", 32'(bus.WRITE_PTR_O), 32'd0);
    checkOutput("flush_commit_count", 32'(bus.COUNT_O), 32'd0);
    checkOutput("flush_commit_write", 32'(bus.WRITE_O), 32'd0);
    checkOutput("flush_commit_trg", 32'(bus.TRG_DELAYED_O), 32'd0);

    $display("[TB] streaming: full FIFO holds the pending word");
    for (int i = 0; i < 8; i++) writeWord(16'hD000 + 16'(i));
    checkOutput("full_count", 32'(bus.COUNT_O), 32'd8);
    writeWord(16'hD008);
    checkOutput("full_hold_write", 32'(bus.WRITE_O), 32'd1);
    checkOutput("full_hold_wptr", 32'(bus.WRITE_PTR_O), 32'd0);
    checkOutput("full_hold_count", 32'(bus.COUNT_O), 32'd8);
    applyStimulus(1'b1, 16'hD009, 1'b0, 1'b0);
    checkOutput("full_overwrite", 32'(bus.DMEM_O), 32'hD009);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
    checkOutput("full_read_load", 32'(bus.LOAD_O), 32'd1);
    checkOutput("full_read_count", 32'(bus.COUNT_O), 32'd7);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    checkOutput("full_release_wptr", 32'(bus.WRITE_PTR_O), 32'd1);
    checkOutput("full_release_count", 32'(bus.COUNT_O), 32'd8);
    checkOutput("full_release_write", 32'(bus.WRITE_O), 32'd0);
    flush();

    $display("[TB] read request on empty buffer waits for data");
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
    checkOutput("empty_no_load", 32'(bus.LOAD_O), 32'd0);
    applyStimulus(1'b1, 16'hE123, 1'b0, 1'b0);
    checkOutput("empty_store_no_load", 32'(bus.LOAD_O), 32'd0);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    checkOutput("empty_commit_count", 32'(bus.COUNT_O), 32'd1);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
    checkOutput("empty_late_load", 32'(bus.LOAD_O), 32'd1);
    checkOutput("empty_late_data", 32'(bus.DATA_O), 32'hE123);
    checkOutput("empty_late_rptr", 32'(bus.READ_PTR_O), 32'd1);
    step();
    checkOutput("empty_load_pulse", 32'(bus.LOAD_O), 32'd0);

    $display("[TB] asynchronous reset with pending read and write");
    applyStimulus(1'b1, 16'hF00F, 1'b0, 1'b1);
    checkOutput("pre_reset_write", 32'(bus.WRITE_O), 32'd1);
    resetN = 1'b0;
    #2;
    checkOutput("async_load", 32'(bus.LOAD_O), 32'd0);
    checkOutput("async_write", 32'(bus.WRITE_O), 32'd0);
    checkOutput("async_wptr", 32'(bus.WRITE_PTR_O), 32'd0);
    checkOutput("async_rptr", 32'(bus.READ_PTR_O), 32'd0);
    checkOutput("async_count", 32'(bus.COUNT_O), 32'd0);
    checkOutput("async_data", 32'(bus.DATA_O), 32'd0);
    checkOutput("async_dmem", 32'(bus.DMEM_O), 32'd0);
    step();
    resetN = 1'b1;
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    checkOutput("post_reset_wptr", 32'(bus.WRITE_PTR_O), 32'd0);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
    checkOutput("post_reset_load", 32'(bus.LOAD_O), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
    $finish;
  end

endmodule
